// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator for 640x480@60 Hz VGA, clocked from the system
//   clock and advanced once every CLK_DIV clocks. Feeds the pixel renderers
//   with the current position and a visible-area flag, and drives the
//   connector sync pins. Every output is registered on the same edge, so
//   all of them describe the same pixel in any given clock.
//
//   Optional build macro: VGA_FRAME_CNT_EN adds an 8-bit free-running frame
//   counter output (frame_cnt) that steps together with frame_start.
//
// Ports
//   clk          in   system clock (100 MHz)
//   rst_n        in   asynchronous active-low reset
//   pix_tick     out  one-clk strobe, high in the clk where the counters move
//   h_cnt[9:0]   out  horizontal position, 0..H_TOTAL-1
//   v_cnt[9:0]   out  vertical position, 0..V_TOTAL-1
//   valid        out  inside the visible area
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   line_start   out  one-clk pulse when h_cnt becomes 0
//   frame_start  out  one-clk pulse when (h_cnt, v_cnt) becomes (0, 0)
//   frame_cnt    out  [VGA_FRAME_CNT_EN only] frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  // Thresholds are one bit wider than the counters so an end-of-window
  // bound equal to 1024 does not wrap to zero.
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  div;
  logic        tick;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        valid_nxt;
  logic        hs_on;
  logic        vs_on;

  // Next position is always computed; it is only committed on a tick.
  // The derived outputs come from this next position so they land in
  // the same register stage as the counters themselves.
  always_comb begin
    tick  = (div == DIV_LAST);
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    h_ext     = {1'b0, h_nxt};
    v_ext     = {1'b0, v_nxt};
    valid_nxt = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_on     = (h_ext >= HS_BEG) && (h_ext < HS_END);
    vs_on     = (v_ext >= VS_BEG) && (v_ext < VS_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_tick    <= 1'b0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      valid       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + 4'd1;
      pix_tick    <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        h_cnt       <= h_nxt;
        v_cnt       <= v_nxt;
        valid       <= valid_nxt;
        hsync       <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync       <= vs_on ? SYNC_POL : ~SYNC_POL;
        line_start  <= (h_nxt == '0);
        frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (tick && (h_nxt == '0) && (v_nxt == '0)) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share one clock: dut_a uses the full 640x480 timing with
//   CLK_DIV=4; dut_b uses CLK_DIV=1 and a tiny 15x10 raster so frame-level
//   behaviour (vsync, frame wrap, frame period, frame counter) fits in a
//   short run.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;

  always #5 clk = ~clk;

  logic       a_pix_tick, a_valid, a_hsync, a_vsync, a_line_start, a_frame_start;
  logic [9:0] a_h_cnt, a_v_cnt;
  logic       b_pix_tick, b_valid, b_hsync, b_vsync, b_line_start, b_frame_start;
  logic [9:0] b_h_cnt, b_v_cnt;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] a_frame_cnt, b_frame_cnt;
`endif

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .pix_tick(a_pix_tick),
    .h_cnt(a_h_cnt), .v_cnt(a_v_cnt), .valid(a_valid),
    .hsync(a_hsync), .vsync(a_vsync),
    .line_start(a_line_start), .frame_start(a_frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(a_frame_cnt)
`endif
  );

  // 15 x 10 raster: hsync on h 10..12, vsync on v 7..8, visible h<8, v<6.
  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .pix_tick(b_pix_tick),
    .h_cnt(b_h_cnt), .v_cnt(b_v_cnt), .valid(b_valid),
    .hsync(b_hsync), .vsync(b_vsync),
    .line_start(b_line_start), .frame_start(b_frame_start)
`ifdef VGA_FRAME_CNT_EN
    , .frame_cnt(b_frame_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int h, input int v, input bit vld,
                                       input bit hs, input bit vs, input bit ls, input bit fs);
    pack = {7'd0, 10'(h), 10'(v), vld, hs, vs, ls, fs};
  endfunction

  function automatic logic [31:0] pack_a();
    pack_a = pack(int'(a_h_cnt), int'(a_v_cnt), a_valid, a_hsync, a_vsync,
                  a_line_start, a_frame_start);
  endfunction

  function automatic logic [31:0] pack_b();
    pack_b = pack(int'(b_h_cnt), int'(b_v_cnt), b_valid, b_hsync, b_vsync,
                  b_line_start, b_frame_start);
  endfunction

  // Caller releases rst_a_n on a negedge just before calling.
  task automatic check_restart_a();
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk("a_first_tick_latency", 32'(a_pix_tick), 32'(j == 4));
    end
    chk("a_first_tick_outputs", pack_a(), pack(0, 0, 1, 1, 1, 1, 1));
    for (int p = 0; p < 3; p++) begin
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        chk("a_tick_period", 32'(a_pix_tick), 32'(j == 4));
      end
    end
  endtask

  typedef struct {
    int n;     // pix_tick number since reset release (1-based)
    int h;
    int v;
    bit vld;
    bit hs;
    bit ls;
    bit fs;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int tick_a, cyc, hs_low, ls_cnt, stray;
    int mh, mv, last_fs, vs_low, tick_low;

    vecs[0]  = '{640,  639, 0, 1, 1, 0, 0};
    vecs[1]  = '{641,  640, 0, 0, 1, 0, 0};
    vecs[2]  = '{656,  655, 0, 0, 1, 0, 0};
    vecs[3]  = '{657,  656, 0, 0, 0, 0, 0};
    vecs[4]  = '{752,  751, 0, 0, 0, 0, 0};
    vecs[5]  = '{753,  752, 0, 0, 1, 0, 0};
    vecs[6]  = '{800,  799, 0, 0, 1, 0, 0};
    vecs[7]  = '{801,    0, 1, 1, 1, 1, 0};
    vecs[8]  = '{1600, 799, 1, 0, 1, 0, 0};
    vecs[9]  = '{1601,   0, 2, 1, 1, 1, 0};
    vecs[10] = '{1700,  99, 2, 1, 1, 0, 0};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("a_reset_outputs", pack_a(), pack(799, 524, 0, 1, 1, 0, 0));
    chk("a_reset_tick", 32'(a_pix_tick), 32'd0);
    chk("b_reset_outputs", pack_b(), pack(14, 9, 0, 1, 1, 0, 0));

    // ---- dut_a: release, first tick, then table over the first lines ----
    rst_a_n = 1'b1;
    check_restart_a();
    tick_a = 4;
    cyc = 0; hs_low = 0; ls_cnt = 0; stray = 0;
    for (int i = 0; i < 11; i++) begin
      while (tick_a < vecs[i].n && cyc < 20000) begin
        @(negedge clk);
        cyc++;
        if (a_pix_tick) begin
          tick_a++;
          if (tick_a <= 800 && !a_hsync) hs_low++;
          if (a_line_start) ls_cnt++;
        end else if (a_line_start || a_frame_start) begin
          stray++;
        end
      end
      chk("a_vec_reached", 32'(tick_a), 32'(vecs[i].n));
      chk($sformatf("a_vec[%0d]", i), pack_a(),
          pack(vecs[i].h, vecs[i].v, vecs[i].vld, vecs[i].hs, 1'b1, vecs[i].ls, vecs[i].fs));
    end
    chk("a_hsync_low_ticks_line0", 32'(hs_low), 32'd96);
    chk("a_line_start_count", 32'(ls_cnt), 32'd2);
    chk("a_stray_pulses", 32'(stray), 32'd0);

    // ---- dut_a: reset mid-line at h=300 ----
    while (tick_a < 1901 && cyc < 25000) begin
      @(negedge clk);
      cyc++;
      if (a_pix_tick) tick_a++;
    end
    chk("a_pre_reset_pos", pack_a(), pack(300, 2, 1, 1, 1, 0, 0));
    rst_a_n = 1'b0;
    #1;
    chk("a_midline_reset", pack_a(), pack(799, 524, 0, 1, 1, 0, 0));
    chk("a_midline_reset_tick", 32'(a_pix_tick), 32'd0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    check_restart_a();

    // ---- dut_b: CLK_DIV=1, cycle-by-cycle model over two frames ----
    @(negedge clk);
    rst_b_n = 1'b1;
    mh = 14; mv = 9; last_fs = 0; vs_low = 0; tick_low = 0;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      if (mh == 14) begin
        mh = 0;
        mv = (mv == 9) ? 0 : mv + 1;
      end else begin
        mh++;
      end
      chk("b_model", pack_b(),
          pack(mh, mv, (mh < 8) && (mv < 6), !((mh >= 10) && (mh < 13)),
               !((mv >= 7) && (mv < 9)), mh == 0, (mh == 0) && (mv == 0)));
      if (!b_pix_tick) tick_low++;
      if (k <= 150 && !b_vsync) vs_low++;
      if (b_frame_start) begin
        if (last_fs > 0) chk("b_frame_period", 32'(k - last_fs), 32'd150);
        last_fs = k;
      end
    end
    chk("b_tick_always_high", 32'(tick_low), 32'd0);
    chk("b_vsync_low_cycles", 32'(vs_low), 32'd30);
    chk("b_last_frame_start", 32'(last_fs), 32'd301);

    // ---- dut_b: reset mid-frame (position h=4, v=1) ----
    rst_b_n = 1'b0;
    #1;
    chk("b_midframe_reset", pack_b(), pack(14, 9, 0, 1, 1, 0, 0));
    chk("b_midframe_reset_tick", 32'(b_pix_tick), 32'd0);
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    chk("b_restart_outputs", pack_b(), pack(0, 0, 1, 1, 1, 1, 1));
    chk("b_restart_tick", 32'(b_pix_tick), 32'd1);

`ifdef VGA_FRAME_CNT_EN
    begin
      int fsn, fc_stray, guard;
      logic [7:0] prev;
      chk("b_frame_cnt_first", 32'(b_frame_cnt), 32'd1);
      fsn = 1; fc_stray = 0; guard = 0;
      prev = b_frame_cnt;
      while (fsn < 257 && guard < 40000) begin
        @(negedge clk);
        guard++;
        if (b_frame_start) begin
          fsn++;
          chk("b_frame_cnt_step", 32'(b_frame_cnt), 32'(fsn & 255));
        end else if (b_frame_cnt != prev) begin
          fc_stray++;
        end
        prev = b_frame_cnt;
      end
      chk("b_frame_cnt_frames", 32'(fsn), 32'd257);
      chk("b_frame_cnt_final", 32'(b_frame_cnt), 32'd1);
      chk("b_frame_cnt_stray", 32'(fc_stray), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
